// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CSUM,
    DONE,
    ERROR
  } boot_state_t;

  // Word-count header length in bytes (little-endian 32-bit count).
  localparam int BOOT_HDR_BYTES = 4;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words; pulses word_valid the
// cycle after the 4th byte of each word is presented.
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] buf_q, buf_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_data_q, word_data_d;

  // Shift bytes into the top of the buffer so b0 ends up in the low byte.
  always_comb begin
    lane_d       = lane_q;
    buf_d        = buf_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    if (clear) begin
      lane_d = 2'd0;
      buf_d  = '0;
    end else if (byte_valid) begin
      lane_d = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        word_valid_d = 1'b1;
        word_data_d  = {byte_data, buf_q};
      end else begin
        buf_d = {byte_data, buf_q[23:8]};
      end
    end
  end

  // State registers; word data holds its last value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q       <= 2'd0;
      buf_q        <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
    end
  end

  assign lane       = lane_q;
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;

endmodule

// File: rtl/boot_loader.sv
// Framed program loader: header word count, LE payload words written to the
// instruction memory, XOR checksum byte. Holds the cpu in reset until verified.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DEPTH      = 10000,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_byte_tdata,
  input  logic                  s_byte_tvalid,
  output logic                  s_byte_tready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  // Word count/index need one extra bit so N == DEPTH is representable.
  localparam int                  CW      = ADDR_WIDTH + 1;
  localparam logic [31:0]         DEPTH_W = 32'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  boot_state_t           state_q, state_d;
  logic [1:0]            hdr_cnt_q, hdr_cnt_d;
  logic [23:0]           hdr_q, hdr_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_q, cpu_rst_d;

  logic        acc;
  logic [31:0] hdr_full;
  logic [1:0]  lane;
  logic        asm_valid;

  assign s_byte_tready = (state_q == HDR) || (state_q == LOAD) || (state_q == CSUM);
  assign acc           = s_byte_tvalid && s_byte_tready;
  // Full 32-bit count as it stands once the current (4th) header byte lands.
  assign hdr_full      = {s_byte_tdata, hdr_q};

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q != LOAD),
    .byte_valid (acc && (state_q == LOAD)),
    .byte_data  (s_byte_tdata),
    .lane       (lane),
    .word_valid (asm_valid),
    .word_data  (imem_wdata)
  );

  // Next-state, counters, checksum and registered status outputs.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    hdr_d       = hdr_q;
    n_d         = n_q;
    word_cnt_d  = word_cnt_q;
    csum_d      = csum_q;
    imem_addr_d = imem_addr_q;
    case (state_q)
      IDLE: state_d = HDR;
      HDR: if (acc) begin
        hdr_d     = {s_byte_tdata, hdr_q[23:8]};
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'(BOOT_HDR_BYTES - 1)) begin
          // Range-check the full 32-bit count before narrowing it.
          if (hdr_full == 32'd0 || hdr_full > DEPTH_W) begin
            state_d = ERROR;
          end else begin
            n_d     = hdr_full[CW-1:0];
            state_d = LOAD;
          end
        end
      end
      LOAD: if (acc) begin
        csum_d = csum_q ^ s_byte_tdata;
        if (lane == 2'd3) begin
          imem_addr_d = BASE_A + word_cnt_q[ADDR_WIDTH-1:0];
          word_cnt_d  = word_cnt_q + CW'(1);
          if (word_cnt_q == n_q - CW'(1)) state_d = CSUM;
        end
      end
      CSUM: if (acc) begin
        state_d = (s_byte_tdata == csum_q) ? DONE : ERROR;
      end
      default: state_d = state_q;
    endcase
    done_d    = (state_q == DONE);
    error_d   = (state_q == ERROR);
    cpu_rst_d = (state_q != DONE);
  end

  // State register; rst aborts any load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= 2'd0;
      hdr_q       <= '0;
      n_q         <= '0;
      word_cnt_q  <= '0;
      csum_q      <= 8'd0;
      imem_addr_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_q       <= hdr_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      csum_q      <= csum_d;
      imem_addr_q <= imem_addr_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  assign imem_we   = asm_valid;
  assign imem_addr = imem_addr_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good frames, gapped stream, header range
// errors, bad checksum and reset mid-load.
module tb_boot_loader;

  localparam int DEPTH = 10000;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_byte_tdata = 8'd0;
  logic          s_byte_tvalid = 1'b0;
  logic          s_byte_tready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst, done, error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [7:0]    fr[$];

  boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_byte_tdata  (s_byte_tdata),
    .s_byte_tvalid (s_byte_tvalid),
    .s_byte_tready (s_byte_tready),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_rst       (cpu_rst),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Log every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'd0;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_byte_tdata  = b;
    s_byte_tvalid = 1'b1;
    while (!s_byte_tready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_byte_tready) begin
      chk("tready_timeout", {31'd0, s_byte_tready}, 32'd1);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    s_byte_tvalid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    s_byte_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_tready"},  {31'd0, s_byte_tready}, 32'd0);
    chk({tag, "_we"},      {31'd0, imem_we},       32'd0);
    chk({tag, "_addr"},    {18'd0, imem_addr},     32'd0);
    chk({tag, "_wdata"},   imem_wdata,             32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst},       32'd1);
    chk({tag, "_done"},    {31'd0, done},          32'd0);
    chk({tag, "_error"},   {31'd0, error},         32'd0);
    wr_addr.delete();
    wr_data.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Header for N, payload, and a checksum byte (corrupted when bad_csum).
  task automatic build(input logic [31:0] n, input logic [7:0] pl[$], input bit bad_csum);
    fr = '{n[7:0], n[15:8], n[23:16], n[31:24]};
    foreach (pl[i]) fr.push_back(pl[i]);
    fr.push_back(bad_csum ? 8'h00 : xor_of(pl));
  endtask

  task automatic chk_status(input string tag, input bit exp_done, input bit exp_err);
    repeat (2) @(negedge clk);
    chk({tag, "_done"},    {31'd0, done},    {31'd0, exp_done});
    chk({tag, "_error"},   {31'd0, error},   {31'd0, exp_err});
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
  endtask

  logic [7:0] pl[$];

  initial begin
    do_reset("rst0");

    // N=2: words 0x00000013 and 0xDEADBEEF; XOR of this payload is 0x31.
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk("csum_model", {24'd0, xor_of(pl)}, 32'h31);
    build(32'd2, pl, 1'b0);
    send_seq(fr, 0);
    chk_status("n2", 1'b1, 1'b0);
    chk("n2_wcnt", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("n2_a0", {18'd0, wr_addr[0]}, 32'd0);
      chk("n2_d0", wr_data[0], 32'h0000_0013);
      chk("n2_a1", {18'd0, wr_addr[1]}, 32'd1);
      chk("n2_d1", wr_data[1], 32'hDEAD_BEEF);
    end
    chk("n2_tready_done", {31'd0, s_byte_tready}, 32'd0);

    // Same frame with random valid gaps.
    do_reset("rst1");
    send_seq(fr, 5);
    chk_status("gap", 1'b1, 1'b0);
    chk("gap_wcnt", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("gap_a0", {18'd0, wr_addr[0]}, 32'd0);
      chk("gap_d0", wr_data[0], 32'h0000_0013);
      chk("gap_a1", {18'd0, wr_addr[1]}, 32'd1);
      chk("gap_d1", wr_data[1], 32'hDEAD_BEEF);
    end

    // N=0 header.
    do_reset("rst2");
    fr = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(fr, 0);
    chk_status("n0", 1'b0, 1'b1);
    chk("n0_tready", {31'd0, s_byte_tready}, 32'd0);
    repeat (5) @(negedge clk);
    chk("n0_wcnt", wr_addr.size(), 0);

    // N=DEPTH+1 = 0x2711.
    do_reset("rst3");
    fr = '{8'h11, 8'h27, 8'h00, 8'h00};
    send_seq(fr, 0);
    chk_status("big", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("big_wcnt", wr_addr.size(), 0);

    // N=0x01000001: low bits look like 1, high byte must still be rejected.
    do_reset("rst4");
    fr = '{8'h01, 8'h00, 8'h00, 8'h01};
    send_seq(fr, 0);
    chk_status("hi", 1'b0, 1'b1);
    chk("hi_wcnt", wr_addr.size(), 0);

    // N=1 with wrong checksum (0x00, correct is 0x04).
    do_reset("rst5");
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    build(32'd1, pl, 1'b1);
    send_seq(fr, 0);
    chk_status("bad", 1'b0, 1'b1);
    chk("bad_wcnt", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("bad_a0", {18'd0, wr_addr[0]}, 32'd0);
      chk("bad_d0", wr_data[0], 32'h0403_0201);
    end

    // Reset after 6 payload bytes, then a fresh frame.
    do_reset("rst6");
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_seq(fr, 0);
    do_reset("mid");
    pl = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    build(32'd2, pl, 1'b0);
    send_seq(fr, 2);
    chk_status("re", 1'b1, 1'b0);
    chk("re_wcnt", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("re_a0", {18'd0, wr_addr[0]}, 32'd0);
      chk("re_d0", wr_data[0], 32'h1234_5678);
      chk("re_a1", {18'd0, wr_addr[1]}, 32'd1);
      chk("re_d1", wr_data[1], 32'h0BAD_F00D);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
